// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants for the two-port memory arbiter
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;

    localparam int DEFAULT_MAX_OUT = 4;
    localparam int NUM_PORTS       = 2;

endpackage

// File: rtl/arb_out_counter.sv
// rtl/arb_out_counter.sv - outstanding-read counter with full and zero-next flags
module arb_out_counter #(
    parameter int MAX_OUT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [2:0] o_count,
    output logic       o_full,
    output logic       o_zero_next
);

    logic [2:0] count_next;

    // Issue and return in the same cycle cancel out.
    always_comb begin
        count_next = o_count;
        if (i_inc && !i_dec) begin
            count_next = o_count + 3'd1;
        end else if (!i_inc && i_dec) begin
            count_next = o_count - 3'd1;
        end
    end

    assign o_full      = (o_count == 3'(MAX_OUT));
    assign o_zero_next = (count_next == 3'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_count <= 3'd0;
        end else begin
            o_count <= count_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (icache/dcache) arbiter onto one backing memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_OUT = DEFAULT_MAX_OUT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_c0_mem_addr,
    input  logic        i_c0_mem_ren,
    input  logic        i_c0_mem_wen,
    input  logic [31:0] i_c0_mem_wdata,
    output logic        o_c0_mem_ready,
    output logic [31:0] o_c0_mem_rdata,
    output logic        o_c0_mem_valid,
    input  logic [31:0] i_c1_mem_addr,
    input  logic        i_c1_mem_ren,
    input  logic        i_c1_mem_wen,
    input  logic [31:0] i_c1_mem_wdata,
    output logic        o_c1_mem_ready,
    output logic [31:0] o_c1_mem_rdata,
    output logic        o_c1_mem_valid,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_err
);

    logic [1:0]           state, state_next;
    logic                 last_grant, last_grant_next;
    logic [NUM_PORTS-1:0] req;
    logic                 own0, own1;
    logic                 sel_ren, sel_wen;
    logic [2:0]           out_count;
    logic                 full, zero_next;
    logic                 issue, ret, spurious;

    assign req  = {i_c1_mem_ren | i_c1_mem_wen, i_c0_mem_ren | i_c0_mem_wen};
    assign own0 = (state == ST_OWN0);
    assign own1 = (state == ST_OWN1);

    always_comb begin
        sel_ren     = 1'b0;
        sel_wen     = 1'b0;
        o_mem_addr  = 32'd0;
        o_mem_wdata = 32'd0;
        if (own0) begin
            sel_ren     = i_c0_mem_ren;
            sel_wen     = i_c0_mem_wen;
            o_mem_addr  = i_c0_mem_addr;
            o_mem_wdata = i_c0_mem_wdata;
        end else if (own1) begin
            sel_ren     = i_c1_mem_ren;
            sel_wen     = i_c1_mem_wen;
            o_mem_addr  = i_c1_mem_addr;
            o_mem_wdata = i_c1_mem_wdata;
        end
    end

    // A simultaneous ren+wen is treated as a write; reads stall while saturated.
    assign o_mem_wen = sel_wen;
    assign o_mem_ren = sel_ren & ~sel_wen & ~full;

    assign o_c0_mem_ready = own0 & i_mem_ready & ~full;
    assign o_c1_mem_ready = own1 & i_mem_ready & ~full;

    assign issue    = o_mem_ren & i_mem_ready;
    assign ret      = i_mem_valid & (out_count != 3'd0);
    assign spurious = i_mem_valid & (out_count == 3'd0);

    // Outstanding reads only exist while a port owns the memory, so the
    // current owner is always the port a return belongs to.
    assign o_c0_mem_rdata = i_mem_rdata;
    assign o_c1_mem_rdata = i_mem_rdata;
    assign o_c0_mem_valid = ret & own0;
    assign o_c1_mem_valid = ret & own1;

    arb_out_counter #(
        .MAX_OUT(MAX_OUT)
    ) u_out_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (issue),
        .i_dec      (ret),
        .o_count    (out_count),
        .o_full     (full),
        .o_zero_next(zero_next)
    );

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            ST_IDLE: begin
                if (&req) begin
                    state_next = last_grant ? ST_OWN0 : ST_OWN1;
                end else if (req[0]) begin
                    state_next = ST_OWN0;
                end else if (req[1]) begin
                    state_next = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                // Hold through the drain of outstanding reads before releasing.
                if (!(sel_ren | sel_wen) && zero_next) begin
                    state_next      = ST_IDLE;
                    last_grant_next = own1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            o_err      <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            if (spurious) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule
